// File: rtl/m_fetch_queue.sv
// m_fetch_queue: instruction prefetch queue between the 1-cycle synchronous imem and decode.
// Ports:
//   w_clk, w_rst          clock, asynchronous active-high reset
//   w_redirect(_pc)       flush the queue and refetch from w_redirect_pc
//   w_halt                stop issuing fetches; queued entries keep draining
//   r_imem_addr           registered fetch PC driven to the memory
//   w_imem_dout           memory word, valid the cycle after its address
//   w_deq_*               head entry over a valid/ready handshake (NOP/zeros when empty)
//   w_count               occupied entries
// Optional feature: define PREDECODE_EN to store a branch bit per entry and compute the
// head branch target; otherwise w_deq_br and w_deq_tpc are constant 0.
module m_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 11,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_redirect,
  input  logic [AW-1:0] w_redirect_pc,
  input  logic          w_halt,
  output logic [AW-1:0] r_imem_addr,
  input  logic [31:0]   w_imem_dout,
  input  logic          w_deq_ready,
  output logic          w_deq_valid,
  output logic [31:0]   w_deq_ir,
  output logic [AW-1:0] w_deq_pc,
  output logic [AW-1:0] w_deq_pc4,
  output logic          w_deq_br,
  output logic [AW-1:0] w_deq_tpc,
  output logic [4:0]    w_count
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [4:0] count;
  logic inflight;
  logic [AW-1:0] r_ifpc;
  logic [31:0] q_ir [DEPTH];
  logic [AW-1:0] q_pc [DEPTH];
  logic pop, push, issue;
  assign w_count = count;
  assign w_deq_valid = count != 5'd0;
  assign pop = w_deq_valid & w_deq_ready;
  assign push = inflight & ~w_redirect;
  // Credit check counts the word already in flight so a capture can never overflow.
  assign issue = ~w_rst & ~w_redirect & ~w_halt &
                 (({1'b0, count} + 6'(inflight) - 6'(pop)) < 6'(DEPTH));
  assign w_deq_ir = w_deq_valid ? q_ir[rd_ptr] : 32'h20;
  assign w_deq_pc = w_deq_valid ? q_pc[rd_ptr] : '0;
  assign w_deq_pc4 = w_deq_valid ? q_pc[rd_ptr] + AW'(1) : '0;
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_imem_addr <= RESET_PC;
      r_ifpc <= '0;
      inflight <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (w_redirect) begin
      r_imem_addr <= w_redirect_pc;
      inflight <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        r_imem_addr <= r_imem_addr + AW'(1);
        r_ifpc <= r_imem_addr;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + 5'(push) - 5'(pop);
    end
  end
  always_ff @(posedge w_clk) begin
    if (push) begin
      q_ir[wr_ptr] <= w_imem_dout;
      q_pc[wr_ptr] <= r_ifpc;
    end
  end
`ifdef PREDECODE_EN
  logic q_br [DEPTH];
  always_ff @(posedge w_clk) begin
    if (push) q_br[wr_ptr] <= (w_imem_dout[31:26] == 6'h4) || (w_imem_dout[31:26] == 6'h5);
  end
  assign w_deq_br = w_deq_valid & q_br[rd_ptr];
  assign w_deq_tpc = w_deq_valid ? w_deq_pc4 + AW'(w_deq_ir[10:0]) : '0;
`else
  assign w_deq_br = 1'b0;
  assign w_deq_tpc = '0;
`endif
`ifdef IVERILOG
  always @(posedge w_clk) begin
    if (!w_rst && push) assert (count < 5'(DEPTH));
  end
`endif
endmodule

// File: tb/tb_m_fetch_queue.sv
// tb_m_fetch_queue: directed checks of the prefetch queue against a 1-cycle synchronous memory model.
module tb_m_fetch_queue;
  logic w_clk, w_rst, w_redirect, w_halt, w_deq_ready, w_deq_valid, w_deq_br;
  logic [10:0] w_redirect_pc, r_imem_addr, w_deq_pc, w_deq_pc4, w_deq_tpc;
  logic [31:0] w_imem_dout, w_deq_ir;
  logic [4:0] w_count;
  logic bne_mode;
  int n_cmp = 0;
  int n_bad = 0;

  m_fetch_queue dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_redirect(w_redirect), .w_redirect_pc(w_redirect_pc),
    .w_halt(w_halt), .r_imem_addr(r_imem_addr), .w_imem_dout(w_imem_dout),
    .w_deq_ready(w_deq_ready), .w_deq_valid(w_deq_valid), .w_deq_ir(w_deq_ir),
    .w_deq_pc(w_deq_pc), .w_deq_pc4(w_deq_pc4), .w_deq_br(w_deq_br),
    .w_deq_tpc(w_deq_tpc), .w_count(w_count)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Memory word k holds k, except the branch test plants a BNE at 0x010.
  always_ff @(posedge w_clk)
    w_imem_dout <= (bne_mode && r_imem_addr == 11'h010) ? 32'h1485_0003 : {21'd0, r_imem_addr};

  task automatic tick;
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset;
    w_rst = 1; w_redirect = 0; w_redirect_pc = '0; w_halt = 0; w_deq_ready = 0; bne_mode = 0;
    tick;
    w_rst = 0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (w_count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", w_count); end
    n_cmp++; if (w_deq_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", w_deq_valid); end
    n_cmp++; if (r_imem_addr !== 11'd0) begin n_bad++; $display("FAIL reset_addr got %h exp 0", r_imem_addr); end
    n_cmp++; if (w_deq_ir !== 32'h20) begin n_bad++; $display("FAIL reset_ir got %h exp 20", w_deq_ir); end
    n_cmp++; if (w_deq_pc !== 11'd0 || w_deq_pc4 !== 11'd0) begin n_bad++; $display("FAIL reset_pc got %h/%h exp 0/0", w_deq_pc, w_deq_pc4); end
    n_cmp++; if (w_deq_br !== 1'b0 || w_deq_tpc !== 11'd0) begin n_bad++; $display("FAIL reset_br got %b/%h exp 0/0", w_deq_br, w_deq_tpc); end
  endtask

  task automatic test_stream;
    do_reset;
    w_deq_ready = 1;
    tick;
    n_cmp++; if (w_deq_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid got %b exp 0", w_deq_valid); end
    tick;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (w_deq_valid !== 1'b1 || w_deq_pc !== 11'(i) || w_deq_ir !== 32'(i) || w_deq_pc4 !== 11'(i + 1))
        begin n_bad++; $display("FAIL stream_%0d got v=%b pc=%h ir=%h pc4=%h exp v=1 pc=%h", i, w_deq_valid, w_deq_pc, w_deq_ir, w_deq_pc4, i); end
      tick;
    end
  endtask

  task automatic test_full;
    do_reset;
    for (int i = 0; i < 10; i++) tick;
    n_cmp++; if (w_count !== 5'd4) begin n_bad++; $display("FAIL full_count got %0d exp 4", w_count); end
    n_cmp++; if (r_imem_addr !== 11'd4) begin n_bad++; $display("FAIL full_addr got %h exp 4", r_imem_addr); end
    w_deq_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (w_deq_valid !== 1'b1 || w_deq_pc !== 11'(i) || w_deq_ir !== 32'(i))
        begin n_bad++; $display("FAIL drain_%0d got v=%b pc=%h ir=%h exp pc=%h", i, w_deq_valid, w_deq_pc, w_deq_ir, i); end
      tick;
    end
  endtask

  task automatic test_redirect;
    do_reset;
    for (int i = 0; i < 4; i++) tick;
    n_cmp++; if (w_count !== 5'd3) begin n_bad++; $display("FAIL redir_pre_count got %0d exp 3", w_count); end
    w_redirect = 1; w_redirect_pc = 11'h100;
    tick;
    w_redirect = 0; w_deq_ready = 1;
    n_cmp++; if (w_count !== 5'd0 || w_deq_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush got c=%0d v=%b exp 0/0", w_count, w_deq_valid); end
    n_cmp++; if (r_imem_addr !== 11'h100) begin n_bad++; $display("FAIL redir_addr got %h exp 100", r_imem_addr); end
    tick;
    n_cmp++; if (w_deq_valid !== 1'b0) begin n_bad++; $display("FAIL redir_bubble got %b exp 0", w_deq_valid); end
    tick;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (w_deq_valid !== 1'b1 || w_deq_pc !== 11'(11'h100 + i) || w_deq_ir !== 32'(11'h100 + i))
        begin n_bad++; $display("FAIL redir_%0d got v=%b pc=%h ir=%h exp pc=%h", i, w_deq_valid, w_deq_pc, w_deq_ir, 11'h100 + i); end
      tick;
    end
  endtask

  task automatic test_halt;
    do_reset;
    for (int i = 0; i < 3; i++) tick;
    n_cmp++; if (w_count !== 5'd2 || r_imem_addr !== 11'd3) begin n_bad++; $display("FAIL halt_pre got c=%0d a=%h exp 2/3", w_count, r_imem_addr); end
    w_halt = 1; w_deq_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (w_deq_valid !== 1'b1 || w_deq_pc !== 11'(i)) begin n_bad++; $display("FAIL halt_pop_%0d got v=%b pc=%h exp pc=%h", i, w_deq_valid, w_deq_pc, i); end
      tick;
    end
    tick; tick;
    n_cmp++; if (w_deq_valid !== 1'b0 || w_count !== 5'd0) begin n_bad++; $display("FAIL halt_empty got v=%b c=%0d exp 0/0", w_deq_valid, w_count); end
    n_cmp++; if (r_imem_addr !== 11'd3) begin n_bad++; $display("FAIL halt_frozen got %h exp 3", r_imem_addr); end
    w_halt = 0;
    tick; tick;
    n_cmp++; if (w_deq_valid !== 1'b1 || w_deq_pc !== 11'd3 || w_deq_ir !== 32'd3) begin n_bad++; $display("FAIL halt_resume got v=%b pc=%h exp 1/3", w_deq_valid, w_deq_pc); end
  endtask

  task automatic test_async_reset;
    do_reset;
    w_deq_ready = 1;
    for (int i = 0; i < 5; i++) tick;
    #2 w_rst = 1;
    #1;
    n_cmp++; if (w_count !== 5'd0 || w_deq_valid !== 1'b0) begin n_bad++; $display("FAIL arst_clear got c=%0d v=%b exp 0/0", w_count, w_deq_valid); end
    n_cmp++; if (r_imem_addr !== 11'd0 || w_deq_ir !== 32'h20) begin n_bad++; $display("FAIL arst_addr got a=%h ir=%h exp 0/20", r_imem_addr, w_deq_ir); end
    w_rst = 0;
    tick; tick;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (w_deq_valid !== 1'b1 || w_deq_pc !== 11'(i)) begin n_bad++; $display("FAIL arst_restart_%0d got v=%b pc=%h exp pc=%h", i, w_deq_valid, w_deq_pc, i); end
      tick;
    end
  endtask

  task automatic test_wrap;
    do_reset;
    w_redirect = 1; w_redirect_pc = 11'h7FF;
    tick;
    w_redirect = 0; w_deq_ready = 1;
    tick; tick;
    n_cmp++; if (w_deq_pc !== 11'h7FF || w_deq_pc4 !== 11'h000 || w_deq_ir !== 32'h7FF)
      begin n_bad++; $display("FAIL wrap_head got pc=%h pc4=%h ir=%h exp 7ff/000/7ff", w_deq_pc, w_deq_pc4, w_deq_ir); end
    tick;
    n_cmp++; if (w_deq_valid !== 1'b1 || w_deq_pc !== 11'h000 || w_deq_pc4 !== 11'h001)
      begin n_bad++; $display("FAIL wrap_next got v=%b pc=%h pc4=%h exp 1/000/001", w_deq_valid, w_deq_pc, w_deq_pc4); end
  endtask

  task automatic test_predecode;
    logic exp_br;
    logic [10:0] exp_tpc;
`ifdef PREDECODE_EN
    exp_br = 1'b1; exp_tpc = 11'h014;
`else
    exp_br = 1'b0; exp_tpc = 11'h000;
`endif
    do_reset;
    bne_mode = 1;
    w_redirect = 1; w_redirect_pc = 11'h010;
    tick;
    w_redirect = 0;
    tick; tick;
    n_cmp++; if (w_deq_pc !== 11'h010 || w_deq_ir !== 32'h1485_0003) begin n_bad++; $display("FAIL pd_head got pc=%h ir=%h exp 010/14850003", w_deq_pc, w_deq_ir); end
    n_cmp++; if (w_deq_br !== exp_br) begin n_bad++; $display("FAIL pd_br got %b exp %b", w_deq_br, exp_br); end
    n_cmp++; if (w_deq_tpc !== exp_tpc) begin n_bad++; $display("FAIL pd_tpc got %h exp %h", w_deq_tpc, exp_tpc); end
    w_deq_ready = 1;
    tick;
    n_cmp++; if (w_deq_pc !== 11'h011 || w_deq_br !== 1'b0) begin n_bad++; $display("FAIL pd_next got pc=%h br=%b exp 011/0", w_deq_pc, w_deq_br); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_full;
    test_redirect;
    test_halt;
    test_async_reset;
    test_wrap;
    test_predecode;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
